// File: rtl/rv32im_csr_ctrl_if.sv
// Bundle of pipeline request/response, trap-entry and CSR-file port signals
// between rv32im_csr_ctrl (master) and its environment (slave).
interface rv32im_csr_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
);
  // Handshake: a request transfers on a cycle where req_valid_i && req_ready_o;
  // the requester holds req_* stable while req_valid_i is high and not accepted.
  // trap_valid_i is level-held until the one-cycle trap_ack_o pulse.
  logic              req_valid_i;
  logic              req_ready_o;
  logic [CSR_AW-1:0] req_addr_i;
  logic [2:0]        req_funct3_i;
  logic [XLEN-1:0]   req_operand_i;
  logic              req_rd_zero_i;
  logic              resp_valid_o;
  logic [XLEN-1:0]   resp_rdata_o;
  logic              resp_err_o;
  logic              trap_valid_i;
  logic [XLEN-1:0]   trap_pc_i;
  logic [XLEN-1:0]   trap_cause_i;
  logic [XLEN-1:0]   trap_tval_i;
  logic              trap_ack_o;
  logic [CSR_AW-1:0] csr_addr_o;
  logic [XLEN-1:0]   csr_wdata_o;
  logic              csr_we_o;
  logic              csr_re_o;
  logic [XLEN-1:0]   csr_rdata_i;

  modport master (
    input  req_valid_i, req_addr_i, req_funct3_i, req_operand_i, req_rd_zero_i,
    input  trap_valid_i, trap_pc_i, trap_cause_i, trap_tval_i, csr_rdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, trap_ack_o,
    output csr_addr_o, csr_wdata_o, csr_we_o, csr_re_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_funct3_i, req_operand_i, req_rd_zero_i,
    output trap_valid_i, trap_pc_i, trap_cause_i, trap_tval_i, csr_rdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, trap_ack_o,
    input  csr_addr_o, csr_wdata_o, csr_we_o, csr_re_o
  );
endinterface

// File: rtl/rv32im_csr_ctrl.sv
// CSR file sequencer: arbitrates CSR instructions against trap entry, performs
// read-modify-write for CSRRW/RS/RC(+I) and the fixed trap-entry write sequence.
module rv32im_csr_ctrl #(
  parameter int                XLEN         = 32,
  parameter int                CSR_AW       = 12,
  parameter logic [CSR_AW-1:0] ADDR_MSTATUS = 12'h300,
  parameter logic [CSR_AW-1:0] ADDR_MEPC    = 12'h341,
  parameter logic [CSR_AW-1:0] ADDR_MCAUSE  = 12'h342,
  parameter logic [CSR_AW-1:0] ADDR_MTVAL   = 12'h343
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  rv32im_csr_ctrl_if.master    bus,
  output logic [2:0]           dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE, RD, WR, T_EPC, T_CAUSE, T_TVAL, T_STRD, T_STWR
  } state_t;

  state_t            state;
  logic [CSR_AW-1:0] addr_q;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   op_q;
  logic              rdz_q;
  logic [XLEN-1:0]   cause_q;
  logic [XLEN-1:0]   tval_q;

  logic              req_legal;
  logic              req_skip_rd;
  logic              rd_skip;
  logic [XLEN-1:0]   old_val;
  logic [XLEN-1:0]   new_val;
  logic              wr_en;
  logic [XLEN-1:0]   mst_new;

  assign dbg_state_o     = state;
  // Trap has priority, so a same-cycle trap hides ready from the pipeline.
  assign bus.req_ready_o = (state == IDLE) && !bus.trap_valid_i;

  always_comb begin
    req_legal   = bus.req_funct3_i[1:0] != 2'b00;
    req_skip_rd = (bus.req_funct3_i[1:0] == 2'b01) && bus.req_rd_zero_i;
    rd_skip     = (f3_q[1:0] == 2'b01) && rdz_q;
    old_val     = rd_skip ? '0 : bus.csr_rdata_i;
    case (f3_q[1:0])
      2'b01:   new_val = op_q;
      2'b10:   new_val = old_val | op_q;
      default: new_val = old_val & ~op_q;
    endcase
    // Set/clear with a zero mask is a pure read and must not touch the CSR.
    wr_en       = (f3_q[1:0] == 2'b01) || (op_q != '0);
    mst_new     = bus.csr_rdata_i;
    mst_new[7]  = bus.csr_rdata_i[3];
    mst_new[3]  = 1'b0;
    mst_new[12:11] = 2'b11;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE;
      addr_q           <= '0;
      f3_q             <= '0;
      op_q             <= '0;
      rdz_q            <= 1'b0;
      cause_q          <= '0;
      tval_q           <= '0;
      bus.resp_valid_o <= 1'b0;
      bus.resp_rdata_o <= '0;
      bus.resp_err_o   <= 1'b0;
      bus.trap_ack_o   <= 1'b0;
      bus.csr_addr_o   <= '0;
      bus.csr_wdata_o  <= '0;
      bus.csr_we_o     <= 1'b0;
      bus.csr_re_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.resp_valid_o <= 1'b0;
          bus.trap_ack_o   <= 1'b0;
          bus.csr_we_o     <= 1'b0;
          bus.csr_re_o     <= 1'b0;
          bus.csr_addr_o   <= '0;
          bus.csr_wdata_o  <= '0;
          if (bus.trap_valid_i) begin
            state           <= T_EPC;
            cause_q         <= bus.trap_cause_i;
            tval_q          <= bus.trap_tval_i;
            bus.csr_we_o    <= 1'b1;
            bus.csr_addr_o  <= ADDR_MEPC;
            bus.csr_wdata_o <= bus.trap_pc_i;
          end else if (bus.req_valid_i) begin
            if (!req_legal) begin
              bus.resp_valid_o <= 1'b1;
              bus.resp_err_o   <= 1'b1;
              bus.resp_rdata_o <= '0;
            end else begin
              state          <= RD;
              addr_q         <= bus.req_addr_i;
              f3_q           <= bus.req_funct3_i;
              op_q           <= bus.req_operand_i;
              rdz_q          <= bus.req_rd_zero_i;
              bus.csr_re_o   <= !req_skip_rd;
              bus.csr_addr_o <= req_skip_rd ? '0 : bus.req_addr_i;
            end
          end
        end
        RD: begin
          state            <= WR;
          bus.csr_re_o     <= 1'b0;
          bus.csr_we_o     <= wr_en;
          bus.csr_addr_o   <= wr_en ? addr_q : '0;
          bus.csr_wdata_o  <= wr_en ? new_val : '0;
          bus.resp_valid_o <= 1'b1;
          bus.resp_rdata_o <= old_val;
          bus.resp_err_o   <= 1'b0;
        end
        WR: begin
          state            <= IDLE;
          bus.csr_we_o     <= 1'b0;
          bus.csr_addr_o   <= '0;
          bus.csr_wdata_o  <= '0;
          bus.resp_valid_o <= 1'b0;
        end
        T_EPC: begin
          state           <= T_CAUSE;
          bus.csr_addr_o  <= ADDR_MCAUSE;
          bus.csr_wdata_o <= cause_q;
        end
        T_CAUSE: begin
          state           <= T_TVAL;
          bus.csr_addr_o  <= ADDR_MTVAL;
          bus.csr_wdata_o <= tval_q;
        end
        T_TVAL: begin
          state           <= T_STRD;
          bus.csr_we_o    <= 1'b0;
          bus.csr_re_o    <= 1'b1;
          bus.csr_addr_o  <= ADDR_MSTATUS;
          bus.csr_wdata_o <= '0;
        end
        T_STRD: begin
          state           <= T_STWR;
          bus.csr_re_o    <= 1'b0;
          bus.csr_we_o    <= 1'b1;
          bus.csr_addr_o  <= ADDR_MSTATUS;
          bus.csr_wdata_o <= mst_new;
          bus.trap_ack_o  <= 1'b1;
        end
        T_STWR: begin
          state           <= IDLE;
          bus.csr_we_o    <= 1'b0;
          bus.csr_addr_o  <= '0;
          bus.csr_wdata_o <= '0;
          bus.trap_ack_o  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
